// File: rtl/mdio_controller_if.sv
// Host/PHY-facing signal bundle of the MDIO management controller.
// The master modport is the controller itself; slave is the host + line side.
interface mdio_controller_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );
endinterface

// File: rtl/mdio_controller.sv
// Clause-22 MDIO management station: serialises a 32-bit frame MSB-first with a
// divided MDC, and on reads captures the 16 data bits returned on MDIO_IN.
module mdio_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    mdio_controller_if.master bus
);
    localparam int unsigned FRAME_W = 32;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    PH_HALF   = PW'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] RX_TOP    = BIT_W'(15);
    localparam logic [BIT_W-1:0] DRIVE_MIN = BIT_W'(19);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_nxt;
    logic [FRAME_W-1:0]  frame_q, frame_nxt;
    logic                is_read_q, is_read_nxt;
    logic [BIT_W-1:0]    bit_cnt_q, bit_nxt, bit_dec;
    logic [PW-1:0]       phase_q, phase_nxt;
    logic [DATA_W-2:0]   shreg_q, shreg_nxt;
    logic                mdc_q, mdc_nxt;
    logic                out_q, out_nxt;
    logic                oe_q, oe_nxt;
    logic [DATA_W-1:0]   rd_data_q, rd_data_nxt;
    logic                data_rdy_q, data_rdy_nxt;
    logic                busy_q, busy_nxt;

    // State and all outputs registered; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            is_read_q  <= 1'b0;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            shreg_q    <= '0;
            mdc_q      <= 1'b0;
            out_q      <= 1'b0;
            oe_q       <= 1'b0;
            rd_data_q  <= '0;
            data_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            frame_q    <= frame_nxt;
            is_read_q  <= is_read_nxt;
            bit_cnt_q  <= bit_nxt;
            phase_q    <= phase_nxt;
            shreg_q    <= shreg_nxt;
            mdc_q      <= mdc_nxt;
            out_q      <= out_nxt;
            oe_q       <= oe_nxt;
            rd_data_q  <= rd_data_nxt;
            data_rdy_q <= data_rdy_nxt;
            busy_q     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        frame_nxt    = frame_q;
        is_read_nxt  = is_read_q;
        bit_nxt      = bit_cnt_q;
        phase_nxt    = phase_q;
        shreg_nxt    = shreg_q;
        mdc_nxt      = mdc_q;
        out_nxt      = out_q;
        oe_nxt       = oe_q;
        rd_data_nxt  = rd_data_q;
        data_rdy_nxt = 1'b0;
        busy_nxt     = busy_q;
        bit_dec      = bit_cnt_q - BIT_W'(1);

        unique case (state_q)
            IDLE: begin
                mdc_nxt  = 1'b0;
                out_nxt  = 1'b0;
                oe_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (bus.MDIO_START) begin
                    state_nxt   = SHIFT;
                    frame_nxt   = bus.T_DATA;
                    is_read_nxt = (bus.T_DATA[29:28] == 2'b10);
                    bit_nxt     = BIT_W'(FRAME_W - 1);
                    phase_nxt   = '0;
                    shreg_nxt   = '0;
                    out_nxt     = bus.T_DATA[FRAME_W-1];
                    oe_nxt      = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    // Last cycle of MDC high: sample the PHY's data bit here.
                    if (is_read_q && bit_cnt_q <= RX_TOP) begin
                        shreg_nxt = {shreg_q[DATA_W-3:0], bus.MDIO_IN};
                    end
                    if (bit_cnt_q == '0) begin
                        state_nxt = IDLE;
                        mdc_nxt   = 1'b0;
                        out_nxt   = 1'b0;
                        oe_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        if (is_read_q) begin
                            rd_data_nxt  = {shreg_q, bus.MDIO_IN};
                            data_rdy_nxt = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_dec;
                        phase_nxt = '0;
                        mdc_nxt   = 1'b0;
                        // Reads release the line from turnaround onward.
                        oe_nxt    = !is_read_q || (bit_cnt_q >= DRIVE_MIN);
                        out_nxt   = oe_nxt & frame_q[bit_dec];
                    end
                end else begin
                    phase_nxt = phase_q + PW'(1);
                    mdc_nxt   = (phase_nxt >= PH_HALF);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.MDC      = mdc_q;
    assign bus.MDIO_OUT = out_q;
    assign bus.MDIO_OE  = oe_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.DATA_RDY = data_rdy_q;
    assign bus.BUSY     = busy_q;
endmodule

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
- Management-station side of the MDIO link; sits directly upstream of mdio_receptor.
- Takes a 32-bit clause-22 frame from the host, derives MDC from the system clock, and serialises the frame MSB-first on MDIO_OUT/MDIO_OE.
- On read frames it releases the line at turnaround, shifts the 16 data bits in from MDIO_IN, and presents them on RD_DATA with a one-cycle DATA_RDY strobe.

Parameters:
- CLK_DIV, 4: CLK cycles per MDC period. Must be even and >= 2. MDC is low for the first CLK_DIV/2 cycles of each bit and high for the second half.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-low reset.
- MDIO_START  input  1  one-cycle request; sampled only while idle.
- T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA.
- MDIO_IN  input  1  serial data from the PHY side (mdio_receptor MDIO_IN).
- MDC  output  1  management clock.
- MDIO_OUT  output  1  serial data toward the PHY.
- MDIO_OE  output  1  1 = controller drives MDIO_OUT.
- RD_DATA  output  16  last read result.
- DATA_RDY  output  1  one-cycle pulse when RD_DATA updates.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (RESET=0 at a rising edge of CLK):
  - MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0.
  - State=IDLE; internal counters and shift register cleared.
  - Reset mid-frame aborts the frame immediately, with no DATA_RDY and no partial RD_DATA update.
- IDLE:
  - MDC is held 0 and MDIO_OE=0.
  - MDIO_START=1 at edge k: latch T_DATA, capture is_read = (T_DATA[29:28]==2'b10), go to SHIFT.
  - BUSY=1 and bit 31 appears on MDIO_OUT from cycle k+1.
- SHIFT:
  - A bit counter runs 31 down to 0; a phase counter runs 0..CLK_DIV-1 within each bit.
  - MDC = 0 for phase < CLK_DIV/2, 1 otherwise.
  - MDIO_OUT/MDIO_OE change only at phase 0, so a bit is stable through the whole MDC high phase for the receiver to sample.
  - Write (OP≠10, including the illegal codes 00/11): MDIO_OE=1 for all 32 bits; MDIO_OUT = frame bit.
  - Read:
    - MDIO_OE=1, MDIO_OUT = frame bit for bits 31..18.
    - MDIO_OE=0, MDIO_OUT=0 for bits 17..0.
    - MDIO_IN is sampled at phase CLK_DIV-1 of bits 15..0 and shifted MSB-first into a holding register.
    - Bits 17..16 (TA) are not sampled.
- End of frame (bit 0, phase CLK_DIV-1, at edge k+32*CLK_DIV):
  - Return to IDLE; MDC=0, MDIO_OE=0, MDIO_OUT=0, BUSY=0 from the next cycle.
  - Read: RD_DATA is loaded with the 16 sampled bits in the same edge; DATA_RDY=1 for exactly the following cycle.
  - Write: RD_DATA is unchanged and DATA_RDY stays 0.
- Frame timing:
  - Frame length is exactly 32*CLK_DIV cycles.
  - BUSY is high for cycles k+1 .. k+32*CLK_DIV.
  - DATA_RDY is high at cycle k+32*CLK_DIV+1.
- MDIO_START handling:
  - Ignored while BUSY=1; T_DATA changes while BUSY=1 do not affect the frame in flight.
  - MDIO_START in the cycle DATA_RDY is high is accepted, since the block is already IDLE; the next frame's bit 31 follows one cycle later.
- RD_DATA holds its value until the next completed read or reset.

Test Plan:
- Write frame, CLK_DIV=4, T_DATA=32'h5A5ABCD5 (OP=01):
  - MDIO_OE=1 for 128 cycles; the MDIO_OUT bit sequence equals T_DATA MSB-first.
  - MDC toggles every 2 cycles; DATA_RDY never asserts; BUSY=0 at cycle k+129.
- Read frame, T_DATA=32'h6A2C0000 (OP=10), bench drives MDIO_IN = 16'hABCD bit-wise during bits 15..0:
  - MDIO_OE drops after bit 18.
  - RD_DATA=16'hABCD with a one-cycle DATA_RDY pulse at k+129.
- Back-to-back: MDIO_START pulsed again while BUSY=1 → ignored.
- Back-to-back: MDIO_START pulsed in the DATA_RDY cycle → second frame starts next cycle with correct first bit.
- RESET=0 at bit 10 of a read:
  - All outputs return to their reset values on the next edge; RD_DATA keeps 16'h0000; no DATA_RDY.
  - A subsequent read completes normally.
- Illegal OP=11, T_DATA=32'hF0000001: driven as a write (MDIO_OE=1 for all 32 bits); RD_DATA unchanged.
- CLK_DIV=2: frame length 64 cycles; MDC has a 50% duty cycle and equals CLK/2; read of 16'h1234 returns 16'h1234.
